fifo_read_ctrl: RTL and testbench

FIFO_READ_CTRL -- requirements
Module: fifo_read_ctrl

---
 rtl/fifo_read_ctrl.sv | 160 ++++++++++++++++
 tb/tb_fifo_read_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl
//
// Purpose:
//   Read-side controller that pulls bytes out of a FIFO and presents them to
//   an I2C transmit shifter, one transfer of length_i bytes per start_i.
//
// Optional feature:
//   FIFO_RD_UNDERRUN_DETECT_EN - when defined, underrun_o becomes a sticky
//   flag set while the controller waits in LOAD on an empty FIFO. Cleared by
//   reset or by an accepted start_i. When undefined, underrun_o is tied to 0.
//
// Ports:
//   read_clock_i     in   read-domain clock (rising edge)
//   read_reset_i     in   synchronous active-high reset
//   start_i          in   single-cycle transfer request (IDLE only)
//   length_i         in   byte count, sampled with an accepted start_i
//   abort_i          in   cancels the current transfer, highest priority after reset
//   fifo_data_i      in   FIFO head word, valid while fifo_empty_i is 0
//   fifo_empty_i     in   FIFO empty flag
//   fifo_read_inc_o  out  pops the FIFO head in the cycle it is high
//   tx_data_o        out  byte presented to the shifter
//   tx_valid_o       out  tx_data_o is valid
//   tx_ready_i       in   shifter ready
//   busy_o           out  controller not IDLE
//   done_o           out  one-cycle completion pulse
//   remaining_o      out  bytes not yet accepted by the shifter
//   underrun_o       out  sticky FIFO starvation flag (see above)
//   debug_state_o    out  current FSM state encoding (IDLE=0 LOAD=1 PRESENT=2 DONE=3)
//
// Handshake: a byte moves when tx_valid_o and tx_ready_i are both high at a
// rising edge; tx_data_o is held stable while tx_valid_o is high and
// tx_ready_i is low.

module fifo_read_ctrl #(
  parameter int data_size  = 8,
  parameter int count_size = 8
) (
  input  logic                  read_clock_i,
  input  logic                  read_reset_i,
  input  logic                  start_i,
  input  logic [count_size-1:0] length_i,
  input  logic                  abort_i,
  input  logic [data_size-1:0]  fifo_data_i,
  input  logic                  fifo_empty_i,
  output logic                  fifo_read_inc_o,
  output logic [data_size-1:0]  tx_data_o,
  output logic                  tx_valid_o,
  input  logic                  tx_ready_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [count_size-1:0] remaining_o,
  output logic                  underrun_o,
  output logic [1:0]            debug_state_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    PRESENT = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [count_size-1:0] ONE_CNT = count_size'(1);

  state_t state, state_next;
  logic   handshake;
  logic   more_left;
  logic   start_accept;
  logic   pop;

  assign handshake    = (state == PRESENT) && tx_ready_i;
  assign more_left    = remaining_o > ONE_CNT;
  assign start_accept = (state == IDLE) && start_i && !abort_i;

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          state_next = (length_i == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        if (!fifo_empty_i) begin
          pop        = 1'b1;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        if (handshake) begin
          if (!more_left) begin
            // last byte accepted: nothing more to fetch
            state_next = DONE;
          end else if (!fifo_empty_i) begin
            // refill in the same cycle for back-to-back bytes
            pop = 1'b1;
          end else begin
            state_next = LOAD;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // abort overrides every transition and suppresses the pop
    if (abort_i) begin
      state_next = IDLE;
      pop        = 1'b0;
    end
    if (read_reset_i) begin
      pop = 1'b0;
    end
  end

  always_ff @(posedge read_clock_i) begin
    if (read_reset_i) begin
      state       <= IDLE;
      tx_data_o   <= '0;
      remaining_o <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        tx_data_o <= fifo_data_i;
      end
      if (abort_i) begin
        remaining_o <= '0;
      end else if (start_accept) begin
        remaining_o <= length_i;
      end else if (handshake) begin
        remaining_o <= remaining_o - ONE_CNT;
      end
    end
  end

`ifdef FIFO_RD_UNDERRUN_DETECT_EN
  always_ff @(posedge read_clock_i) begin
    if (read_reset_i) begin
      underrun_o <= 1'b0;
    end else if (start_accept) begin
      underrun_o <= 1'b0;
    end else if ((state == LOAD) && fifo_empty_i) begin
      underrun_o <= 1'b1;
    end
  end
`else
  assign underrun_o = 1'b0;
`endif

  assign fifo_read_inc_o = pop;
  assign tx_valid_o      = (state == PRESENT);
  assign busy_o          = (state != IDLE);
  assign done_o          = (state == DONE);
  assign debug_state_o   = state;

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb_fifo_read_ctrl
//
// Directed bench for fifo_read_ctrl. A queue models the FIFO feeding the
// block; bytes accepted by the shifter are collected and compared against an
// expected queue after each complete transfer.

module tb_fifo_read_ctrl;

  localparam int DW = 8;
  localparam int CW = 8;

`ifdef FIFO_RD_UNDERRUN_DETECT_EN
  localparam logic UNDERRUN_EXP = 1'b1;
`else
  localparam logic UNDERRUN_EXP = 1'b0;
`endif

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_LOAD    = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;

  logic          clk;
  logic          read_reset_i;
  logic          start_i;
  logic [CW-1:0] length_i;
  logic          abort_i;
  logic [DW-1:0] fifo_data_i;
  logic          fifo_empty_i;
  logic          fifo_read_inc_o;
  logic [DW-1:0] tx_data_o;
  logic          tx_valid_o;
  logic          tx_ready_i;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] remaining_o;
  logic          underrun_o;
  logic [1:0]    debug_state_o;

  fifo_read_ctrl #(.data_size(DW), .count_size(CW)) dut (
    .read_clock_i    (clk),
    .read_reset_i    (read_reset_i),
    .start_i         (start_i),
    .length_i        (length_i),
    .abort_i         (abort_i),
    .fifo_data_i     (fifo_data_i),
    .fifo_empty_i    (fifo_empty_i),
    .fifo_read_inc_o (fifo_read_inc_o),
    .tx_data_o       (tx_data_o),
    .tx_valid_o      (tx_valid_o),
    .tx_ready_i      (tx_ready_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .remaining_o     (remaining_o),
    .underrun_o      (underrun_o),
    .debug_state_o   (debug_state_o)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int total = 0;
  int bad = 0;
  int pop_count = 0;
  int done_count = 0;
  int pops0;
  int dones0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic refresh_fifo();
    fifo_empty_i = (fifo_q.size() == 0);
    fifo_data_i  = (fifo_q.size() == 0) ? '0 : fifo_q[0];
  endtask

  task automatic push(input logic [DW-1:0] v);
    fifo_q.push_back(v);
    refresh_fifo();
  endtask

  task automatic flush();
    fifo_q.delete();
    got_q.delete();
    exp_q.delete();
    refresh_fifo();
  endtask

  // One clock: sample pre-edge handshake/pop/done, then update the FIFO model.
  task automatic tick();
    logic          p, h, d;
    logic [DW-1:0] dv;
    @(posedge clk);
    p  = fifo_read_inc_o;
    h  = tx_valid_o && tx_ready_i;
    d  = done_o;
    dv = tx_data_o;
    #1;
    if (p) begin
      pop_count++;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
    end
    if (h) got_q.push_back(dv);
    if (d) done_count++;
    refresh_fifo();
    #1;
  endtask

  task automatic wait_done(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_o) break;
    end
    check(tag, done_o, 1'b1);
  endtask

  task automatic sb_compare(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      check({tag, "_byte"}, got_q.pop_front(), exp_q.pop_front());
    end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    read_reset_i = 1'b1;
    start_i      = 1'b0;
    length_i     = '0;
    abort_i      = 1'b0;
    tx_ready_i   = 1'b0;
    refresh_fifo();

    // reset
    tick();
    tick();
    check("rst_tx_data", tx_data_o, 8'h00);
    check("rst_tx_valid", tx_valid_o, 1'b0);
    check("rst_remaining", remaining_o, 8'd0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_done", done_o, 1'b0);
    check("rst_underrun", underrun_o, 1'b0);
    check("rst_inc", fifo_read_inc_o, 1'b0);
    read_reset_i = 1'b0;
    tick();

    // back-to-back transfer of three bytes
    push(8'hA1); push(8'hB2); push(8'hC3);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2); exp_q.push_back(8'hC3);
    pops0 = pop_count; dones0 = done_count;
    tx_ready_i = 1'b1; start_i = 1'b1; length_i = 8'd3;
    tick();
    start_i = 1'b0; #1;
    check("s1_load_state", debug_state_o, ST_LOAD);
    check("s1_load_rem", remaining_o, 8'd3);
    check("s1_load_inc", fifo_read_inc_o, 1'b1);
    check("s1_load_valid", tx_valid_o, 1'b0);
    tick();
    check("s1_b0_data", tx_data_o, 8'hA1);
    check("s1_b0_valid", tx_valid_o, 1'b1);
    tick();
    check("s1_b1_data", tx_data_o, 8'hB2);
    check("s1_b1_rem", remaining_o, 8'd2);
    tick();
    check("s1_b2_data", tx_data_o, 8'hC3);
    check("s1_b2_rem", remaining_o, 8'd1);
    check("s1_last_inc", fifo_read_inc_o, 1'b0);
    tick();
    check("s1_done", done_o, 1'b1);
    check("s1_done_valid", tx_valid_o, 1'b0);
    check("s1_done_rem", remaining_o, 8'd0);
    tick();
    check("s1_idle_done", done_o, 1'b0);
    check("s1_idle_busy", busy_o, 1'b0);
    check("s1_hold_data", tx_data_o, 8'hC3);
    check("s1_pops", pop_count - pops0, 3);
    check("s1_dones", done_count - dones0, 1);
    sb_compare("s1");

    // FIFO starvation: second byte arrives late
    push(8'h55);
    exp_q.push_back(8'h55); exp_q.push_back(8'h66);
    dones0 = done_count;
    start_i = 1'b1; length_i = 8'd2;
    tick();
    start_i = 1'b0;
    tick();  // pop 0x55
    tick();  // handshake, FIFO empty -> LOAD
    tick();  // waiting in LOAD
    check("s2_wait_state", debug_state_o, ST_LOAD);
    check("s2_wait_rem", remaining_o, 8'd1);
    check("s2_wait_valid", tx_valid_o, 1'b0);
    check("s2_underrun", underrun_o, UNDERRUN_EXP);
    tick(); tick();
    push(8'h66);
    wait_done("s2_done_seen", 10);
    check("s2_underrun_sticky", underrun_o, UNDERRUN_EXP);
    tick();
    check("s2_dones", done_count - dones0, 1);
    sb_compare("s2");

    // shifter stalls for four cycles
    push(8'h11); push(8'h22);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22);
    tx_ready_i = 1'b0; start_i = 1'b1; length_i = 8'd2;
    tick();
    start_i = 1'b0;
    check("s3_underrun_clr", underrun_o, 1'b0);
    tick();
    pops0 = pop_count;
    for (int i = 0; i < 4; i++) begin
      check("s3_stall_data", tx_data_o, 8'h11);
      check("s3_stall_valid", tx_valid_o, 1'b1);
      check("s3_stall_rem", remaining_o, 8'd2);
      check("s3_stall_inc", fifo_read_inc_o, 1'b0);
      tick();
    end
    check("s3_stall_pops", pop_count - pops0, 0);
    tx_ready_i = 1'b1;
    wait_done("s3_done_seen", 10);
    tick();
    sb_compare("s3");

    // zero-length transfer
    push(8'h99);
    pops0 = pop_count;
    start_i = 1'b1; length_i = 8'd0;
    tick();
    start_i = 1'b0; #1;
    check("s4_done", done_o, 1'b1);
    check("s4_inc", fifo_read_inc_o, 1'b0);
    tick();
    check("s4_after_done", done_o, 1'b0);
    check("s4_after_busy", busy_o, 1'b0);
    check("s4_pops", pop_count - pops0, 0);
    flush();

    // abort after one handshake
    push(8'h31); push(8'h32); push(8'h33); push(8'h34);
    dones0 = done_count;
    start_i = 1'b1; length_i = 8'd4;
    tick();
    start_i = 1'b0;
    tick();  // pop 0x31
    tick();  // handshake 0x31, pop 0x32
    check("s5_pre_data", tx_data_o, 8'h32);
    check("s5_pre_rem", remaining_o, 8'd3);
    abort_i = 1'b1; #1;
    check("s5_abort_inc", fifo_read_inc_o, 1'b0);
    tick();
    abort_i = 1'b0;
    check("s5_state", debug_state_o, ST_IDLE);
    check("s5_busy", busy_o, 1'b0);
    check("s5_rem", remaining_o, 8'd0);
    check("s5_left", fifo_q.size(), 2);
    tick();
    check("s5_no_done", done_count - dones0, 0);
    flush();

    // reset mid-transfer, then a normal single-byte transfer
    push(8'h41); push(8'h42); push(8'h43);
    dones0 = done_count;
    tx_ready_i = 1'b0; start_i = 1'b1; length_i = 8'd3;
    tick();
    start_i = 1'b0;
    tick();
    check("s6_pre_state", debug_state_o, ST_PRESENT);
    read_reset_i = 1'b1; tx_ready_i = 1'b1; #1;
    check("s6_rst_inc", fifo_read_inc_o, 1'b0);
    tick();
    read_reset_i = 1'b0;
    check("s6_tx_data", tx_data_o, 8'h00);
    check("s6_tx_valid", tx_valid_o, 1'b0);
    check("s6_rem", remaining_o, 8'd0);
    check("s6_busy", busy_o, 1'b0);
    check("s6_done", done_o, 1'b0);
    check("s6_underrun", underrun_o, 1'b0);
    flush();
    push(8'h77);
    exp_q.push_back(8'h77);
    start_i = 1'b1; length_i = 8'd1;
    tick();
    start_i = 1'b0;
    wait_done("s6_done_seen", 10);
    tick();
    check("s6_dones", done_count - dones0, 1);
    sb_compare("s6");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // global watchdog
  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
